// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit packed BCD converter (shift-add-3 / double-dabble).
// Define BIN2BCD_SAT_EN to saturate out-of-range inputs to 9999 and raise ovf.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [13:0] bin_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd_out,
    output logic        ovf
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [13:0] shift_q, shift_d;
    logic [19:0] scratch_q, scratch_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] bcd_q, bcd_d;
    logic        done_q, done_d;
    logic [33:0] work;
`ifdef BIN2BCD_SAT_EN
    logic        ovf_lat_q, ovf_lat_d;
    logic        ovf_q, ovf_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
`ifdef BIN2BCD_SAT_EN
            ovf_lat_q <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
`ifdef BIN2BCD_SAT_EN
            ovf_lat_q <= ovf_lat_d;
            ovf_q     <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;
        work      = {scratch_q, shift_q};
`ifdef BIN2BCD_SAT_EN
        ovf_lat_d = ovf_lat_q;
        ovf_d     = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = bin_in;
                    scratch_d = '0;
                    cnt_d     = '0;
`ifdef BIN2BCD_SAT_EN
                    ovf_lat_d = (bin_in > 14'd9999);
`endif
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // Adjust every digit in place, then shift the joined {scratch, shift} word.
                for (int unsigned i = 0; i < 5; i++) begin
                    if (work[14 + 4*i +: 4] >= 4'd5)
                        work[14 + 4*i +: 4] = work[14 + 4*i +: 4] + 4'd3;
                end
                work      = work << 1;
                scratch_d = work[33:14];
                shift_d   = work[13:0];
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == 4'd13)
                    state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
`ifdef BIN2BCD_SAT_EN
                if (ovf_lat_q) begin
                    bcd_d = 16'h9999;
                    ovf_d = 1'b1;
                end else begin
                    bcd_d = scratch_q[15:0];
                    ovf_d = 1'b0;
                end
`else
                bcd_d   = scratch_q[15:0];
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign bcd_out = bcd_q;
`ifdef BIN2BCD_SAT_EN
    assign ovf     = ovf_q;
`else
    assign ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq; honours BIN2BCD_SAT_EN when compiled with it.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        ovf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cyc = 0;

    bin2bcd_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Decimal digits by plain division; saturate or wrap as the build selects.
    function automatic logic [15:0] ref_bcd(input int v);
        int t;
        int r;
`ifdef BIN2BCD_SAT_EN
        t = (v > 9999) ? 9999 : v;
`else
        t = v % 10000;
`endif
        r = (t / 1000 % 10) * 4096 + (t / 100 % 10) * 256 + (t / 10 % 10) * 16 + (t % 10);
        return r[15:0];
    endfunction

    function automatic logic ref_ovf(input int v);
`ifdef BIN2BCD_SAT_EN
        return v > 9999;
`else
        return (v < 0);
`endif
    endfunction

    // Called #1 after a rising edge; returns #1 after the done edge (or after an abort).
    task automatic convert(input int v, input int inj_at, input int abort_at);
        int lat;
        start  = 1'b1;
        bin_in = v[13:0];
        @(posedge clk); #1;
        start  = 1'b0;
        bin_in = 14'($urandom);
        check_eq("busy_accept", {30'd0, busy, done}, 32'd2);
        lat = 0;
        while (lat < 15) begin
            @(posedge clk); #1;
            lat++;
            start = 1'b0;
            if (lat == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_eq("abort_busy_done", {30'd0, busy, done}, 32'd0);
                check_eq("abort_bcd", {16'd0, bcd_out}, 32'd0);
                check_eq("abort_ovf", {31'd0, ovf}, 32'd0);
                rst_n = 1'b1;
                return;
            end
            if (lat < 15) begin
                check_eq("busy_during", {30'd0, busy, done}, 32'd2);
            end else begin
                check_eq("done_at_15", {31'd0, done}, 32'd1);
                check_eq("busy_after_done", {31'd0, busy}, 32'd0);
                check_eq("bcd_out", {16'd0, bcd_out}, {16'd0, ref_bcd(v)});
                check_eq("ovf", {31'd0, ovf}, {31'd0, ref_ovf(v)});
                done_cyc = cyc;
            end
            if (lat == inj_at) begin
                start  = 1'b1;
                bin_in = 14'd1111;
            end
        end
    endtask

    task automatic idle_check(input int n, input logic [15:0] exp_bcd);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            check_eq("idle_busy_done", {30'd0, busy, done}, 32'd0);
            check_eq("idle_hold_bcd", {16'd0, bcd_out}, {16'd0, exp_bcd});
        end
    endtask

    initial begin
        int d1;
        int v;
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check_eq("rst_bcd", {16'd0, bcd_out}, 32'd0);
        check_eq("rst_ovf", {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        convert(0, -1, -1);
        idle_check(2, ref_bcd(0));

        convert(1234, -1, -1);
        d1 = done_cyc;
        convert(9999, -1, -1);
        check_eq("b2b_gap", done_cyc - d1, 32'd16);

        convert(12345, -1, -1);
        convert(42, -1, -1);

        convert(5678, 5, -1);
        idle_check(20, 16'h5678);

        convert(4321, -1, 7);
        idle_check(20, 16'h0000);
        convert(4321, -1, -1);

        convert(16383, -1, -1);
        convert(10000, -1, -1);
        convert(9, -1, -1);

        for (int i = 0; i < 1100; i++) begin
            if (i % 10 == 9) v = int'($urandom_range(16383, 10000));
            else             v = int'($urandom_range(9999, 0));
            convert(v, -1, -1);
            if ($urandom_range(1, 0) == 1) begin
                @(posedge clk); #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
